// File: rtl/shift_add_mul16_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM encoding and sizes.
package shift_add_mul16_pkg;

  // 2'b11 is unused; the FSM treats it as illegal and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int MUL_W    = 16;
  localparam int MUL_ITER = 16;

endpackage

// File: rtl/shift_add_mul16_cska16.sv
// CSKA16: 16-bit carry-skip adder built from four 4-bit ripple blocks.
// When every bit of a block propagates, the block's carry-in skips the ripple chain.
module CSKA16 (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] Sum,
  output logic        Cout
);

  // Ripple inside each block, skip mux between blocks.
  always_comb begin
    logic       c;
    logic       c_blk_in;
    logic       rc;
    logic       p_all;
    logic       p;
    Sum = '0;
    c   = Cin;
    for (int blk = 0; blk < 4; blk++) begin
      c_blk_in = c;
      rc       = c;
      p_all    = 1'b1;
      for (int i = 0; i < 4; i++) begin
        p                 = A[blk*4+i] ^ B[blk*4+i];
        Sum[blk*4+i]      = p ^ rc;
        rc                = (A[blk*4+i] & B[blk*4+i]) | (p & rc);
        p_all             = p_all & p;
      end
      c = p_all ? c_blk_in : rc;
    end
    Cout = c;
  end

endmodule

// File: rtl/shift_add_mul16.sv
// Sequential 16x16 -> 32-bit unsigned multiplier, one shift-and-add step per clock
// through a single CSKA16. Result appears 17 clocks after the accepted start edge.
module shift_add_mul16
  import shift_add_mul16_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  // The adder is fixed-width, so only a 16-bit operand width can be built.
  if (WIDTH != MUL_W) begin : g_bad_width
    $error("shift_add_mul16: WIDTH must be 16");
  end
  if ((1 << CNT_W) <= WIDTH) begin : g_bad_cnt
    $error("shift_add_mul16: CNT_W too narrow to count WIDTH iterations");
  end

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     add_b;
  logic [WIDTH-1:0]     sum;
  logic                 carry;

  // Add the multiplicand only when the current multiplier LSB is set.
  assign add_b = q_q[0] ? m_q : '0;

  CSKA16 u_adder (
    .A    (acc_q),
    .B    (add_b),
    .Cin  (1'b0),
    .Sum  (sum),
    .Cout (carry)
  );

  // Next-state, datapath update and status outputs.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        done = (state_q == DONE);
        if (start) begin
          m_d     = a;
          q_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        busy  = 1'b1;
        // Carry is kept: it shifts into the top of ACC, S[0] into the top of Q.
        acc_d = {carry, sum[WIDTH-1:1]};
        q_d   = {sum[0], q_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MUL_ITER - 1)) begin
          product_d = {carry, sum, q_q[WIDTH-1:1]};
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_shift_add_mul16.sv
// Self-checking bench for shift_add_mul16: directed cases plus random operands
// against a plain-arithmetic product model.
module tb_shift_add_mul16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int n_chk;
  int n_err;

  shift_add_mul16 #(.WIDTH(16), .CNT_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One multiply. Start accepted at edge k; RUN occupies the 16 cycles after
  // edges k..k+15; done is seen right after edge k+16 (the 17th clock counting
  // the start edge as clock 1). poke >= 0 pulses start with a=b=1 that many
  // edges into RUN, which must be ignored.
  task automatic do_mul(input logic [15:0] ta, input logic [15:0] tb,
                        input string tag, input int poke);
    logic [31:0] exp;
    int          lat;
    int          busy_cnt;
    bit          got;
    exp = 32'(ta) * 32'(tb);
    @(negedge clk);
    a = ta; b = tb; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    busy_cnt = busy ? 1 : 0;
    lat = 0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (lat == poke) begin
        start = 1'b1; a = 16'd1; b = 16'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      if (busy) busy_cnt++;
      if (done) got = 1;
    end
    start = 1'b0;
    chk({tag, ".latency"}, 32'(lat), 32'd16);
    chk({tag, ".busy_cycles"}, 32'(busy_cnt), 32'd16);
    chk({tag, ".product"}, product, exp);
    @(posedge clk);
    #1;
    chk({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, ".held"}, product, exp);
  endtask

  initial begin
    int          extra_done;
    int          lat;
    bit          got;
    logic [15:0] ra, rb;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #1;
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.done", {31'd0, done}, 32'd0);
    chk("reset.product", product, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_mul(16'd3, 16'd5, "basic", -1);
    do_mul(16'hFFFF, 16'hFFFF, "carry", -1);
    do_mul(16'h1234, 16'h0010, "shift", -1);
    do_mul(16'h0000, 16'hABCD, "zero", -1);

    // start during RUN must neither restart nor queue an operation
    do_mul(16'd7, 16'd9, "ignore", 5);
    extra_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) extra_done++;
    end
    chk("ignore.no_second_op", 32'(extra_done), 32'd0);
    chk("ignore.product_kept", product, 32'h3F);

    // back-to-back: start held high, new operands presented in the DONE cycle
    @(negedge clk);
    a = 16'd2; b = 16'd3; start = 1'b1;
    @(posedge clk);
    #1;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      #1;
      if (done) got = 1;
    end
    chk("b2b.first_product", product, 32'd6);
    a = 16'h0100; b = 16'h0100;
    @(posedge clk);
    #1;
    chk("b2b.no_idle_gap", {31'd0, busy}, 32'd1);
    start = 1'b0;
    lat = 1;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) got = 1;
    end
    chk("b2b.done_spacing", 32'(lat), 32'd17);
    chk("b2b.second_product", product, 32'h00010000);
    @(posedge clk);
    #1;

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    a = 16'hFFFF; b = 16'd2; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset.busy", {31'd0, busy}, 32'd0);
    chk("midreset.done", {31'd0, done}, 32'd0);
    chk("midreset.product", product, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_mul(16'd4, 16'd4, "after_reset", -1);

    // random operands, model is plain multiplication
    for (int n = 0; n < 20; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      do_mul(ra, rb, $sformatf("rand%0d", n), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/shift_add_mul16.md
Name: shift_add_mul16

Overview:
- Sequential 16x16 -> 32-bit unsigned multiplier.
- Computes one shift-and-add step per clock, using one instance of the team's 16-bit carry-skip adder, CSKA16, as its only adder.
- Sits directly upstream of CSKA16. It registers the operands and partial product, drives the adder's A, B and Cin every cycle, and consumes the adder's Sum and Cout.
- Gives the datapath a multiply operation without a combinational array multiplier.

Parameters:
- WIDTH, 16, operand width. Only 16 is legal because CSKA16 is fixed-width; any other value triggers an elaboration-time error.
- CNT_W, 5, iteration counter width. Must hold the value WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a multiply; sampled only in IDLE or DONE.
- a  input  16  multiplicand; captured on the accepted start edge.
- b  input  16  multiplier; captured on the accepted start edge.
- busy  output  1  high while iterating (RUN).
- done  output  1  one-cycle pulse; product is valid and newly updated.
- product  output  32  last completed result; held until the next completion.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Internal registers:
  - M[15:0], multiplicand.
  - ACC[15:0], upper partial product.
  - Q[15:0], multiplier, shifting into the lower product.
  - CNT[CNT_W-1:0].
  - state in {IDLE, RUN, DONE}.
  - product_r[31:0].
- Reset (rst_n low, asynchronous, any state including mid-RUN):
  - state goes to IDLE.
  - M, ACC, Q, CNT and product_r are cleared to 0.
  - busy = 0, done = 0, product = 0.
  - An in-flight operation is discarded with no partial result.
- Adder hookup (combinational every cycle):
  - CSKA16.A = ACC.
  - CSKA16.B = Q[0] ? M : 16'h0000.
  - CSKA16.Cin = 0.
  - The adder's outputs give {C, S}.
- IDLE:
  - busy = 0, done = 0.
  - If start = 1: M <= a, Q <= b, ACC <= 0, CNT <= 0, state goes to RUN.
- RUN:
  - busy = 1.
  - Each edge: ACC <= {C, S[15:1]}, Q <= {S[0], Q[15:1]}, CNT <= CNT + 1.
  - On the edge where CNT == 15 (the 16th iteration): product_r <= {C, S[15:1], S[0], Q[15:1]}, i.e. the post-shift {ACC, Q}; state goes to DONE.
  - start is ignored while in RUN; no queueing, no abort.
- DONE:
  - busy = 0, done = 1 for exactly this one cycle.
  - If start = 1: accept as in IDLE and go straight to RUN (back-to-back operation, no dead cycle).
  - Otherwise go to IDLE.
- Latency: start accepted at edge k; done is high in the cycle after edge k+16 (17 clocks from start edge to done). Throughput is one result per 17 cycles when start is held high.
- Arithmetic:
  - Unsigned only. The adder carry C is never dropped; it becomes ACC[15] after the shift.
  - The result is exact for all inputs, max 0xFFFF*0xFFFF = 0xFFFE0001.
- product changes only on a completing edge or on reset. a and b may change freely after acceptance.
- Zero operands still take the full 16 iterations; there is no early termination.

Decomposition:
- Shared package holds:
  - the state encoding: IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10; 2'b11 is illegal and recovers to IDLE.
  - the constants MUL_W = 16 and MUL_ITER = 16.
- Sub-modules:
  - one instance of the existing CSKA16.
  - no other sub-module; FSM and datapath live in shift_add_mul16.

Test Plan:
- Basic result and latency: reset, then start with a = 3, b = 5.
  - done pulses exactly 17 clocks after the start edge.
  - product = 0x0000000F; busy high for 16 cycles.
- Carry-propagation stress: a = 0xFFFF, b = 0xFFFF.
  - product = 0xFFFE0001 (exercises adder Cout into ACC[15] on every add step).
- Zero and shift cases:
  - a = 0x1234, b = 0x0010 gives product = 0x00012340.
  - a = 0, b = 0xABCD gives product = 0, still with 17-cycle latency.
- Start ignored while busy: start a = 7, b = 9; pulse start with a = 1, b = 1 at cycle 5.
  - Single done pulse; product = 0x0000003F.
  - No second operation begins.
- Back-to-back: hold start high with a = 2, b = 3, then a = 0x0100, b = 0x0100 presented in the DONE cycle.
  - First product = 6; the second operation starts with no idle cycle.
  - Second product = 0x00010000, done 17 cycles after the first done.
- Reset mid-operation: start a = 0xFFFF, b = 2; assert rst_n low asynchronously at cycle 8 (between edges).
  - busy, done and product go to 0 immediately.
  - After release, start a = 4, b = 4 gives product = 16.
